// File: rtl/id_stage_pipe.sv
// id_stage_pipe: registered RV32I instruction-decode stage.
// Decodes an instruction word into datapath controls and a sign-extended
// immediate, then holds the decoded bundle behind a valid/ready handshake.
// Optional feature: define ID_MEXT_EN to decode RV32M (OP, funct7=0x01).
// Without it those encodings are illegal and o_muldiv is always 0.
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_flush              kill the held bundle and the incoming instruction
//   i_in_valid/o_in_ready, i_in_inst, i_in_pc    fetch side
//   o_out_valid/i_out_ready, o_out_pc, o_out_inst execute side
//   o_alu_src1, o_alu_src2, o_alu_op, o_wb_sel, o_reg_we, o_mem_we,
//   o_mem_re, o_branch, o_jump, o_jalr, o_muldiv, o_illegal, o_imm
module id_stage_pipe #(
  parameter int XLEN           = 32,
  parameter bit ILLEGAL_AS_NOP = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [31:0]     i_in_inst,
  input  logic [XLEN-1:0] i_in_pc,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [XLEN-1:0] o_out_pc,
  output logic [31:0]     o_out_inst,
  output logic            o_alu_src1,
  output logic            o_alu_src2,
  output logic [1:0]      o_alu_op,
  output logic [1:0]      o_wb_sel,
  output logic            o_reg_we,
  output logic            o_mem_we,
  output logic            o_mem_re,
  output logic            o_branch,
  output logic            o_jump,
  output logic            o_jalr,
  output logic            o_muldiv,
  output logic            o_illegal,
  output logic [XLEN-1:0] o_imm
);

  // Shift amounts above 31 are only meaningful on a 64-bit datapath.
  localparam bit SHAMT5_ILLEGAL = (XLEN == 32);

  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic            w_rd_zero;
  logic            w_src1, w_src2, w_reg_we, w_mem_we, w_mem_re;
  logic            w_branch, w_jump, w_jalr, w_muldiv, w_illegal;
  logic [1:0]      w_alu_op, w_wb_sel;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  logic            w_kill;
  logic            w_capture;

  assign w_funct3  = i_in_inst[14:12];
  assign w_funct7  = i_in_inst[31:25];
  assign w_rd_zero = (i_in_inst[11:7] == 5'd0);

  always_comb begin
    w_src1    = 1'b0;
    w_src2    = 1'b0;
    w_alu_op  = 2'b00;
    w_wb_sel  = 2'b00;
    w_reg_we  = 1'b0;
    w_mem_we  = 1'b0;
    w_mem_re  = 1'b0;
    w_branch  = 1'b0;
    w_jump    = 1'b0;
    w_jalr    = 1'b0;
    w_muldiv  = 1'b0;
    w_illegal = 1'b0;
    w_imm32   = 32'd0;
    case (i_in_inst[6:0])
      7'b0110111: begin // LUI
        w_src2   = 1'b1;
        w_reg_we = 1'b1;
        w_imm32  = {i_in_inst[31:12], 12'd0};
      end
      7'b0010111: begin // AUIPC
        w_src1   = 1'b1;
        w_src2   = 1'b1;
        w_reg_we = 1'b1;
        w_imm32  = {i_in_inst[31:12], 12'd0};
      end
      7'b1101111: begin // JAL
        w_src1   = 1'b1;
        w_src2   = 1'b1;
        w_wb_sel = 2'b10;
        w_reg_we = 1'b1;
        w_jump   = 1'b1;
        w_imm32  = {{12{i_in_inst[31]}}, i_in_inst[19:12], i_in_inst[20],
                    i_in_inst[30:21], 1'b0};
      end
      7'b1100111: begin // JALR
        w_src2   = 1'b1;
        w_wb_sel = 2'b10;
        w_reg_we = 1'b1;
        w_jump   = 1'b1;
        w_jalr   = 1'b1;
        w_imm32  = {{20{i_in_inst[31]}}, i_in_inst[31:20]};
      end
      7'b1100011: begin // BRANCH
        w_src1    = 1'b1;
        w_alu_op  = 2'b01;
        w_branch  = 1'b1;
        w_illegal = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
        w_imm32   = {{20{i_in_inst[31]}}, i_in_inst[7], i_in_inst[30:25],
                     i_in_inst[11:8], 1'b0};
      end
      7'b0000011: begin // LOAD
        w_src2    = 1'b1;
        w_wb_sel  = 2'b01;
        w_reg_we  = 1'b1;
        w_mem_re  = 1'b1;
        w_illegal = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) ||
                    (w_funct3 == 3'b111);
        w_imm32   = {{20{i_in_inst[31]}}, i_in_inst[31:20]};
      end
      7'b0100011: begin // STORE
        w_src2    = 1'b1;
        w_mem_we  = 1'b1;
        w_illegal = (w_funct3[2] || (w_funct3[1:0] == 2'b11));
        w_imm32   = {{20{i_in_inst[31]}}, i_in_inst[31:25], i_in_inst[11:7]};
      end
      7'b0010011: begin // OP-IMM
        w_src2   = 1'b1;
        w_alu_op = 2'b11;
        w_reg_we = 1'b1;
        w_imm32  = {{20{i_in_inst[31]}}, i_in_inst[31:20]};
        if (SHAMT5_ILLEGAL && (w_funct3[1:0] == 2'b01) && i_in_inst[25])
          w_illegal = 1'b1;
      end
      7'b0110011: begin // OP
        w_alu_op = 2'b10;
        w_reg_we = 1'b1;
        case (w_funct7)
          7'h00: w_illegal = 1'b0;
          7'h20: w_illegal = !((w_funct3 == 3'b000) || (w_funct3 == 3'b101));
`ifdef ID_MEXT_EN
          7'h01: w_muldiv  = 1'b1;
`else
          7'h01: w_illegal = 1'b1;
`endif
          default: w_illegal = 1'b1;
        endcase
      end
      7'b0001111: w_illegal = 1'b0; // FENCE: no-op in this core
      default:    w_illegal = 1'b1; // SYSTEM, unknown, or inst[1:0] != 2'b11
    endcase
  end

  assign w_imm     = XLEN'(signed'(w_imm32));
  assign w_kill    = ILLEGAL_AS_NOP && w_illegal;
  assign o_in_ready = !o_out_valid || i_out_ready;
  assign w_capture  = i_in_valid && o_in_ready && !i_flush;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_out_valid <= 1'b0;
      o_out_pc    <= '0;
      o_out_inst  <= '0;
      o_alu_src1  <= 1'b0;
      o_alu_src2  <= 1'b0;
      o_alu_op    <= 2'b00;
      o_wb_sel    <= 2'b00;
      o_reg_we    <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_re    <= 1'b0;
      o_branch    <= 1'b0;
      o_jump      <= 1'b0;
      o_jalr      <= 1'b0;
      o_muldiv    <= 1'b0;
      o_illegal   <= 1'b0;
      o_imm       <= '0;
    end else if (i_flush) begin
      o_out_valid <= 1'b0;
    end else if (w_capture) begin
      o_out_valid <= 1'b1;
      o_out_pc    <= i_in_pc;
      o_out_inst  <= i_in_inst;
      o_alu_src1  <= w_src1;
      o_alu_src2  <= w_src2;
      o_alu_op    <= w_alu_op;
      o_wb_sel    <= w_wb_sel;
      o_reg_we    <= w_reg_we && !w_rd_zero && !w_kill;
      o_mem_we    <= w_mem_we && !w_kill;
      o_mem_re    <= w_mem_re;
      o_branch    <= w_branch;
      o_jump      <= w_jump;
      o_jalr      <= w_jalr;
      o_muldiv    <= w_muldiv;
      o_illegal   <= w_illegal;
      o_imm       <= w_imm;
    end else if (o_out_valid && i_out_ready) begin
      o_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: expected bundles are queued at issue,
// a negedge monitor pops and compares on every output handshake.
module tb_id_stage_pipe;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        s1;
    logic        s2;
    logic [1:0]  aop;
    logic [1:0]  wb;
    logic        rwe;
    logic        mwe;
    logic        mre;
    logic        br;
    logic        jmp;
    logic        jlr;
    logic        md;
    logic        ill;
    logic [31:0] imm;
  } bundle_t;

  localparam logic L = 1'b0;
  localparam logic H = 1'b1;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        alu_src1, alu_src2;
  logic [1:0]  alu_op, wb_sel;
  logic        reg_we, mem_we, mem_re, branch, jump, jalr, muldiv, illegal;
  logic [31:0] imm;
  bundle_t     act;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int hs_prev  = -10;
  int hs_last  = -10;
  bundle_t q[$];

  id_stage_pipe #(.XLEN(32), .ILLEGAL_AS_NOP(1'b1)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_inst(in_inst), .i_in_pc(in_pc),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_pc(out_pc), .o_out_inst(out_inst),
    .o_alu_src1(alu_src1), .o_alu_src2(alu_src2),
    .o_alu_op(alu_op), .o_wb_sel(wb_sel),
    .o_reg_we(reg_we), .o_mem_we(mem_we), .o_mem_re(mem_re),
    .o_branch(branch), .o_jump(jump), .o_jalr(jalr),
    .o_muldiv(muldiv), .o_illegal(illegal), .o_imm(imm)
  );

  assign act = {out_pc, out_inst, alu_src1, alu_src2, alu_op, wb_sel, reg_we,
                mem_we, mem_re, branch, jump, jalr, muldiv, illegal, imm};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic bundle_t mk(
    input logic [31:0] pc, input logic [31:0] inst,
    input logic s1, input logic s2, input logic [1:0] aop, input logic [1:0] wb,
    input logic rwe, input logic mwe, input logic mre, input logic br,
    input logic jmp, input logic jlr, input logic md, input logic ill,
    input logic [31:0] im);
    bundle_t b;
    b = {pc, inst, s1, s2, aop, wb, rwe, mwe, mre, br, jmp, jlr, md, ill, im};
    return b;
  endfunction

  task automatic chk(input string name, input logic [127:0] a, input logic [127:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  // Monitor: every accepted output bundle must match the head of the queue.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      hs_prev = hs_last;
      hs_last = cyc;
      if (q.size() == 0) begin
        chk("unexpected_bundle", 128'(act), 128'(0));
      end else begin
        bundle_t e;
        e = q.pop_front();
        chk("bundle", 128'(act), 128'(e));
      end
    end
  end

  // Present one instruction; called just after a rising edge.
  task automatic issue(input bundle_t e, input bit push);
    int k;
    in_valid = 1'b1;
    in_inst  = e.inst;
    in_pc    = e.pc;
    k = 0;
    while (in_ready !== 1'b1 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 20) chk("issue_timeout", 128'(0), 128'(1));
    if (push) q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (q.size() != 0) chk("drain_timeout", 128'(q.size()), 128'(0));
  endtask

  bundle_t v_addi, v_sw, v_beq, v_lui, v_jalr, v_mul, v_unk, v_b01, v_badbr;
  bundle_t v_slli, v_sub, v_sll20, v_nop, v_lw, v_jal, snap;

  initial begin
    v_addi  = mk(32'h100, 32'h00500093, L, H, 2'b11, 2'b00, H, L, L, L, L, L, L, L, 32'h5);
    v_sw    = mk(32'h104, 32'h0020A423, L, H, 2'b00, 2'b00, L, H, L, L, L, L, L, L, 32'h8);
    v_beq   = mk(32'h108, 32'hFE000EE3, H, L, 2'b01, 2'b00, L, L, L, H, L, L, L, L, 32'hFFFFFFFC);
    v_lui   = mk(32'h10C, 32'h123452B7, L, H, 2'b00, 2'b00, H, L, L, L, L, L, L, L, 32'h12345000);
    v_jalr  = mk(32'h110, 32'h000080E7, L, H, 2'b00, 2'b10, H, L, L, L, H, H, L, L, 32'h0);
`ifdef ID_MEXT_EN
    v_mul   = mk(32'h114, 32'h022081B3, L, L, 2'b10, 2'b00, H, L, L, L, L, L, H, L, 32'h0);
`else
    v_mul   = mk(32'h114, 32'h022081B3, L, L, 2'b10, 2'b00, L, L, L, L, L, L, L, H, 32'h0);
`endif
    v_unk   = mk(32'h118, 32'h0000007F, L, L, 2'b00, 2'b00, L, L, L, L, L, L, L, H, 32'h0);
    v_b01   = mk(32'h11C, 32'h00500091, L, L, 2'b00, 2'b00, L, L, L, L, L, L, L, H, 32'h0);
    v_badbr = mk(32'h120, 32'h00002063, H, L, 2'b01, 2'b00, L, L, L, H, L, L, L, H, 32'h0);
    v_slli  = mk(32'h124, 32'h02009093, L, H, 2'b11, 2'b00, L, L, L, L, L, L, L, H, 32'h20);
    v_sub   = mk(32'h128, 32'h402081B3, L, L, 2'b10, 2'b00, H, L, L, L, L, L, L, L, 32'h0);
    v_sll20 = mk(32'h12C, 32'h402091B3, L, L, 2'b10, 2'b00, L, L, L, L, L, L, L, H, 32'h0);
    v_nop   = mk(32'h130, 32'h00000013, L, H, 2'b11, 2'b00, L, L, L, L, L, L, L, L, 32'h0);
    v_lw    = mk(32'h134, 32'hFFC12283, L, H, 2'b00, 2'b01, H, L, H, L, L, L, L, L, 32'hFFFFFFFC);
    v_jal   = mk(32'h138, 32'h008000EF, H, H, 2'b00, 2'b10, H, L, L, L, H, L, L, L, 32'h8);

    // Reset held two cycles with a valid instruction present.
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h100;
    @(posedge clk); #1;
    chk("reset_outputs", 128'({out_valid, act}), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    chk("reset_outputs_2", 128'({out_valid, act}), 128'(0));
    chk("in_ready_after_reset", 128'(in_ready), 128'(1));

    issue(v_addi, 1'b1);
    drain();

    // Back-to-back store and branch with the consumer always ready.
    issue(v_sw, 1'b1);
    issue(v_beq, 1'b1);
    drain();
    chk("no_bubble", 128'(hs_last - hs_prev), 128'(1));

    issue(v_lui, 1'b1);
    drain();

    // Stall with jalr held, then flush on the second stalled cycle.
    out_ready = 1'b0;
    issue(v_jalr, 1'b0);
    chk("stall_bundle", 128'({out_valid, act}), 128'({1'b1, v_jalr}));
    chk("stall_in_ready", 128'(in_ready), 128'(0));
    snap = act;
    in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h200;
    @(posedge clk); #1;
    chk("stall_stable", 128'({out_valid, act}), 128'({1'b1, snap}));
    chk("stall_in_ready_2", 128'(in_ready), 128'(0));
    flush = 1'b1;
    @(posedge clk); #1;
    chk("flush_clears_valid", 128'(out_valid), 128'(0));
    flush = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("flush_no_capture", 128'(out_valid), 128'(0));
    out_ready = 1'b1;

    // Flush must also drop an instruction that would otherwise be captured.
    in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h300; flush = 1'b1;
    @(posedge clk); #1;
    chk("flush_incoming", 128'(out_valid), 128'(0));
    flush = 1'b0; in_valid = 1'b0;

    issue(v_mul, 1'b1);
    issue(v_unk, 1'b1);
    issue(v_b01, 1'b1);
    issue(v_badbr, 1'b1);
    issue(v_slli, 1'b1);
    issue(v_sub, 1'b1);
    issue(v_sll20, 1'b1);
    issue(v_nop, 1'b1);
    issue(v_lw, 1'b1);
    issue(v_jal, 1'b1);
    drain();
    @(posedge clk); #1;
    chk("idle_after_drain", 128'(out_valid), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
